// File: rtl/ctrl_bus_gen.sv
// ============================================================================
// Module      : ctrl_bus_gen
// Description : ctrl_bus source for one gobou FC layer. It walks neurons x input
//               words and emits framed bursts plus input/weight read addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_bus_gen #(
  parameter int LWIDTH  = 10,
  parameter int AWIDTH  = 16,
  parameter int D_DRAIN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [LWIDTH-1:0] total_in,
  input  logic [LWIDTH-1:0] total_out,
  input  logic              stall,
  output logic [2:0]        out_ctrl,   // {start, valid, stop}
  output logic [LWIDTH-1:0] in_addr,
  output logic [AWIDTH-1:0] w_addr,
  output logic [LWIDTH-1:0] out_idx,
  output logic              busy,
  output logic              ack
);

  localparam int c_DW = (D_DRAIN > 1) ? $clog2(D_DRAIN) : 1;
  localparam logic [c_DW-1:0] c_DRAIN_LAST = c_DW'(D_DRAIN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  logic [LWIDTH-1:0] r_tin;
  logic [LWIDTH-1:0] r_tout;
  logic [LWIDTH-1:0] r_i;
  logic [LWIDTH-1:0] r_o;
  logic [AWIDTH-1:0] r_w;
  logic [c_DW-1:0]   r_cnt;
  logic              r_start;
  logic              r_valid;
  logic              r_stop;
  logic [LWIDTH-1:0] r_in_addr;
  logic [AWIDTH-1:0] r_w_addr;
  logic [LWIDTH-1:0] r_out_idx;
  logic              r_busy;
  logic              r_ack;

  logic w_last_i;
  logic w_last_o;

  assign w_last_i = (r_i == r_tin - LWIDTH'(1));
  assign w_last_o = (r_o == r_tout - LWIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tin     <= '0;
      r_tout    <= '0;
      r_i       <= '0;
      r_o       <= '0;
      r_w       <= '0;
      r_cnt     <= '0;
      r_start   <= 1'b0;
      r_valid   <= 1'b0;
      r_stop    <= 1'b0;
      r_in_addr <= '0;
      r_w_addr  <= '0;
      r_out_idx <= '0;
      r_busy    <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_valid <= 1'b0;
      r_stop  <= 1'b0;
      r_ack   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_busy <= 1'b1;
            r_tin  <= total_in;
            r_tout <= total_out;
            r_i    <= '0;
            r_o    <= '0;
            r_w    <= '0;
            if ((total_in != '0) && (total_out != '0)) begin
              r_state <= S_START;
            end else begin
              // Empty layer: a single drain cycle places ack two cycles after req.
              r_cnt   <= c_DRAIN_LAST;
              r_state <= S_DRAIN;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_START: begin
          if (!stall) begin
            r_start   <= 1'b1;
            r_out_idx <= r_o;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (!stall) begin
            r_valid   <= 1'b1;
            r_in_addr <= r_i;
            r_w_addr  <= r_w;
            r_out_idx <= r_o;
            r_w       <= r_w + AWIDTH'(1);
            if (w_last_i) begin
              r_stop <= 1'b1;
              r_i    <= '0;
              if (w_last_o) begin
                r_cnt   <= '0;
                r_state <= S_DRAIN;
              end else begin
                r_o     <= r_o + LWIDTH'(1);
                r_state <= S_START;
              end
            end else begin
              r_i <= r_i + LWIDTH'(1);
            end
          end
        end
        S_DRAIN: begin
          if (r_cnt == c_DRAIN_LAST) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + c_DW'(1);
          end
        end
        S_DONE: begin
          r_ack   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_ctrl = {r_start, r_valid, r_stop};
  assign in_addr  = r_in_addr;
  assign w_addr   = r_w_addr;
  assign out_idx  = r_out_idx;
  assign busy     = r_busy;
  assign ack      = r_ack;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_bus_gen.sv
// ============================================================================
// Module      : tb_ctrl_bus_gen
// Description : Scoreboard bench for ctrl_bus_gen; expected bus events are
//               queued by the stimulus and retired by a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_bus_gen;

  localparam int LW = 10;
  localparam int AW = 16;
  localparam int DD = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          stall = 1'b0;
  logic [LW-1:0] total_in = '0;
  logic [LW-1:0] total_out = '0;
  logic [2:0]    out_ctrl;
  logic [LW-1:0] in_addr;
  logic [AW-1:0] w_addr;
  logic [LW-1:0] out_idx;
  logic          busy;
  logic          ack;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // kind: 0 start, 1 valid, 2 ack, 3 illegal encoding
  typedef struct {
    int kind;
    int cyc;
    int ia;
    int wa;
    int oi;
    int stp;
  } exp_t;
  exp_t q[$];

  ctrl_bus_gen #(.LWIDTH(LW), .AWIDTH(AW), .D_DRAIN(DD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .total_in (total_in),
    .total_out(total_out),
    .stall    (stall),
    .out_ctrl (out_ctrl),
    .in_addr  (in_addr),
    .w_addr   (w_addr),
    .out_idx  (out_idx),
    .busy     (busy),
    .ack      (ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input int ia, input int wa,
                         input int oi, input int stp);
    exp_t e;
    e.kind = kind; e.cyc = c; e.ia = ia; e.wa = wa; e.oi = oi; e.stp = stp;
    q.push_back(e);
  endtask

  // Unstalled layer: start, then tin valids per neuron; ack DD+1 after last stop.
  task automatic push_layer(input int base, input int tin, input int tout);
    int t;
    t = base + 1;
    for (int o = 0; o < tout; o++) begin
      push_ev(0, t, 0, 0, 0, 0);
      t++;
      for (int i = 0; i < tin; i++) begin
        push_ev(1, t, i, o * tin + i, o, (i == tin - 1) ? 1 : 0);
        t++;
      end
    end
    push_ev(2, t - 1 + DD + 1, 0, 0, 0, 0);
  endtask

  task automatic issue_req(input int tin, input int tout, output int base);
    total_in  = tin[LW-1:0];
    total_out = tout[LW-1:0];
    req  = 1'b1;
    base = cyc + 1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain_check(input string name);
    int lim;
    lim = cyc + 200;
    while (q.size() != 0 && cyc < lim) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({name, "_pending"}, q.size(), 0);
    q.delete();
  endtask

  always @(negedge clk) begin
    int k;
    exp_t e;
    bit ok;
    if (out_ctrl[2] || out_ctrl[1] || ack) begin
      if (out_ctrl[2] && out_ctrl[1]) k = 3;
      else if (out_ctrl[2] && out_ctrl[0]) k = 3;
      else if (out_ctrl[2]) k = 0;
      else if (out_ctrl[1]) k = 1;
      else k = 2;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event actual kind=%0d cyc=%0d required none", k, cyc);
      end else begin
        e = q.pop_front();
        ok = (e.kind == k) && (e.cyc == cyc);
        if (k == 1)
          ok = ok && (int'(in_addr) == e.ia) && (int'(w_addr) == e.wa) &&
               (int'(out_idx) == e.oi) && (int'(out_ctrl[0]) == e.stp);
        if (k == 2) ok = ok && busy;
        if (!ok) begin
          failures++;
          $display("FAIL bus_event actual kind=%0d cyc=%0d i=%0d w=%0d o=%0d stop=%0d busy=%0d required kind=%0d cyc=%0d i=%0d w=%0d o=%0d stop=%0d",
                   k, cyc, in_addr, w_addr, out_idx, out_ctrl[0], busy,
                   e.kind, e.cyc, e.ia, e.wa, e.oi, e.stp);
        end
      end
    end else if (out_ctrl[0]) begin
      checks++;
      failures++;
      $display("FAIL stop_without_valid actual stop=1 required stop=0 (cyc %0d)", cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", int'(out_ctrl), 0);
    chk("rst_in_addr", int'(in_addr), 0);
    chk("rst_w_addr", int'(w_addr), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(ack), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: 3 inputs x 2 neurons, no stall
    issue_req(3, 2, b);
    push_ev(0, b+1, 0, 0, 0, 0);
    push_ev(1, b+2, 0, 0, 0, 0);
    push_ev(1, b+3, 1, 1, 0, 0);
    push_ev(1, b+4, 2, 2, 0, 1);
    push_ev(0, b+5, 0, 0, 0, 0);
    push_ev(1, b+6, 0, 3, 1, 0);
    push_ev(1, b+7, 1, 4, 1, 0);
    push_ev(1, b+8, 2, 5, 1, 1);
    push_ev(2, b+17, 0, 0, 0, 0);
    chk("t1_busy_running", int'(busy), 1);
    wait_until(b + 17);
    chk("t1_busy_at_ack", int'(busy), 1);
    wait_until(b + 18);
    chk("t1_busy_after_ack", int'(busy), 0);
    drain_check("t1");

    // 2: stall in RUN, in START and in DRAIN
    issue_req(3, 2, b);
    push_ev(0, b+1, 0, 0, 0, 0);
    push_ev(1, b+2, 0, 0, 0, 0);
    push_ev(1, b+5, 1, 1, 0, 0);
    push_ev(1, b+6, 2, 2, 0, 1);
    push_ev(0, b+8, 0, 0, 0, 0);
    push_ev(1, b+9, 0, 3, 1, 0);
    push_ev(1, b+10, 1, 4, 1, 0);
    push_ev(1, b+11, 2, 5, 1, 1);
    push_ev(2, b+20, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      stall = (cyc+1 == b+3) || (cyc+1 == b+4) || (cyc+1 == b+7) ||
              (cyc+1 == b+13) || (cyc+1 == b+14);
      @(negedge clk);
    end
    stall = 1'b0;
    drain_check("t2");

    // 3: single input word per neuron
    issue_req(1, 3, b);
    push_layer(b, 1, 3);
    drain_check("t3");

    // 4: empty layers
    issue_req(0, 5, b);
    push_ev(2, b+2, 0, 0, 0, 0);
    wait_until(b + 3);
    chk("t4a_busy_after_ack", int'(busy), 0);
    drain_check("t4a");
    issue_req(4, 0, b);
    push_ev(2, b+2, 0, 0, 0, 0);
    drain_check("t4b");

    // 5: requests while busy are ignored, including in DRAIN and DONE
    issue_req(2, 2, b);
    push_layer(b, 2, 2);
    for (int k = 0; k < 16; k++) begin
      total_in  = 10'd5;
      total_out = 10'd4;
      req = (cyc+1 == b+3) || (cyc+1 == b+10) || (cyc+1 == b+15);
      @(negedge clk);
    end
    req = 1'b0;
    drain_check("t5");
    chk("t5_busy_idle", int'(busy), 0);

    // 6: async reset mid-RUN, then a clean layer
    issue_req(4, 3, b);
    push_ev(0, b+1, 0, 0, 0, 0);
    push_ev(1, b+2, 0, 0, 0, 0);
    push_ev(1, b+3, 1, 1, 0, 0);
    wait_until(b + 3);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_ctrl", int'(out_ctrl), 0);
    chk("t6_rst_in_addr", int'(in_addr), 0);
    chk("t6_rst_w_addr", int'(w_addr), 0);
    chk("t6_rst_out_idx", int'(out_idx), 0);
    chk("t6_rst_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("t6_pre_pending", q.size(), 0);
    q.delete();
    @(negedge clk);
    issue_req(2, 1, b);
    push_layer(b, 2, 1);
    drain_check("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
